ext_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the pipelined datapath. Accepts an IN_W-bit immediate plus an operation code and a pass-through tag over a valid/ready handshake, and produces the extended OUT_W-bit operand one cycle later. It generalises the single-cycle zero/sign extender with configurable widths and two extra modes: load-upper and branch-offset. It also adds stall/flush-aware buffering so it can sit between the decode stage and the ID/EX boundary.

---
 rtl/ext_pipe_if.sv | 27 ++
 rtl/ext_pipe.sv | 122 ++++++++++++
 tb/tb_ext_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: valid/ready request and response bundle for ext_pipe.
// slave is the block side; master is the producer/consumer side.
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender (zero / sign / load-upper / branch
// offset) with one cycle of latency between the decode stage and ID/EX.
// Build option EXT_PIPE_SKID_EN: two-entry skid buffer with a registered
// in_ready. Without it, a single register stage whose in_ready is
// combinational from out_ready.
// Widths must satisfy OUT_W >= IN_W + 2.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      flush,
    ext_pipe_if.slave bus
);
    localparam int E = OUT_W - IN_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } item_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1
`ifdef EXT_PIPE_SKID_EN
        , S_TWO = 2'd2
`endif
    } state_t;

    // Extension happens at acceptance so the stored item is already final.
    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      op);
        logic [OUT_W-1:0] sx;
        sx = {{E{imm[IN_W-1]}}, imm};
        case (op)
            2'd0:    return {{E{1'b0}}, imm};
            2'd1:    return sx;
            2'd2:    return {imm, {E{1'b0}}};
            default: return {sx[OUT_W-3:0], 2'b00};
        endcase
    endfunction

    state_t state_q, state_d;
    item_t  main_q, new_item;
    logic   acc, drn, ld_main_new;

    assign new_item = '{data: extend(bus.in_imm, bus.in_op), tag: bus.in_tag};

    assign acc = bus.in_valid && bus.in_ready;
    assign drn = (state_q != S_EMPTY) && bus.out_ready;

    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_data  = main_q.data;
    assign bus.out_tag   = main_q.tag;

`ifdef EXT_PIPE_SKID_EN
    item_t skid_q;
    logic  rdy_q, ld_main_skid, ld_skid;

    // in_ready is a flop so there is no path from out_ready to in_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_q <= 1'b1;
        else          rdy_q <= (state_d != S_TWO);
    end
    assign bus.in_ready = rdy_q;
`else
    assign bus.in_ready = (state_q == S_EMPTY) || bus.out_ready;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_EMPTY;
        else          state_q <= state_d;
    end

    // Next state: occupancy follows accepts and drains; flush wins over both.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (acc) state_d = S_ONE;
            S_ONE: begin
                if (!acc && drn)      state_d = S_EMPTY;
`ifdef EXT_PIPE_SKID_EN
                else if (acc && !drn) state_d = S_TWO;
`endif
            end
`ifdef EXT_PIPE_SKID_EN
            S_TWO:   if (drn) state_d = S_ONE;
`endif
            default: state_d = S_EMPTY;
        endcase
        if (flush) state_d = S_EMPTY;
    end

    // Register load enables derived from state and handshakes.
    always_comb begin
        ld_main_new = acc && ((state_q == S_EMPTY) || drn);
`ifdef EXT_PIPE_SKID_EN
        ld_main_skid = (state_q == S_TWO) && drn;
        ld_skid      = (state_q == S_ONE) && acc && !drn;
`endif
    end

    // Main register: new item when main is free or draining, else refill from skid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          main_q <= '0;
        else if (ld_main_new)  main_q <= new_item;
`ifdef EXT_PIPE_SKID_EN
        else if (ld_main_skid) main_q <= skid_q;
`endif
    end

`ifdef EXT_PIPE_SKID_EN
    // Skid register catches the item accepted while main is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     skid_q <= '0;
        else if (ld_skid) skid_q <= new_item;
    end
`endif
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: table-driven vectors plus a scoreboard for ext_pipe, with
// hand-written sequences for backpressure, flush and async reset.
module tb_ext_pipe;
`ifdef EXT_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, flush, flush_n;

    ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) b();
    ext_pipe_if #(.IN_W(8),  .OUT_W(12), .TAG_W(3)) n();

    ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b));
    ext_pipe #(.IN_W(8), .OUT_W(12), .TAG_W(3)) dut_n (
        .clk(clk), .reset_n(reset_n), .flush(flush_n), .bus(n));

    typedef struct { logic [15:0] imm; logic [1:0] op; logic [4:0] tag; logic [31:0] exp; } vec_t;
    typedef struct { logic [7:0] imm; logic [1:0] op; logic [11:0] exp; } nvec_t;
    typedef struct { logic [31:0] d; logic [4:0] t; } exp_t;

    int   checks = 0;
    int   passed = 0;
    exp_t sbq[$];
    int   drained_tags[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] op);
        logic signed [31:0] s;
        s = 32'($signed(imm));
        case (op)
            2'd0:    return {16'h0000, imm};
            2'd1:    return s;
            2'd2:    return {imm, 16'h0000};
            default: return s * 32'sd4;
        endcase
    endfunction

    // Scoreboard: push on accept, pop and compare on drain.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n || flush) sbq.delete();
        else begin
            if (b.in_valid && b.in_ready)
                sbq.push_back(exp_t'{model(b.in_imm, b.in_op), b.in_tag});
            if (b.out_valid && b.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got tag %0d, want no output", b.out_tag);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", 64'(b.out_data), 64'(e.d));
                    chk("sb_tag", 64'(b.out_tag), 64'(e.t));
                    drained_tags.push_back(int'(b.out_tag));
                end
            end
        end
    end

    vec_t  vt[4];
    nvec_t nt[4];
    int    idx, gap;
    logic  acc;
    logic [31:0] saved;

    initial begin
        vt[0] = '{16'h8001, 2'd0, 5'd10, 32'h00008001};
        vt[1] = '{16'h8001, 2'd1, 5'd11, 32'hFFFF8001};
        vt[2] = '{16'h8001, 2'd2, 5'd12, 32'h80010000};
        vt[3] = '{16'h8001, 2'd3, 5'd13, 32'hFFFE0004};
        nt[0] = '{8'h80, 2'd1, 12'hF80};
        nt[1] = '{8'hFF, 2'd3, 12'hFFC};
        nt[2] = '{8'h5A, 2'd2, 12'h5A0};
        nt[3] = '{8'h80, 2'd0, 12'h080};

        reset_n = 1'b0; flush = 1'b0; flush_n = 1'b0;
        b.in_valid = 1'b0; b.in_imm = '0; b.in_op = '0; b.in_tag = '0; b.out_ready = 1'b0;
        n.in_valid = 1'b0; n.in_imm = '0; n.in_op = '0; n.in_tag = '0; n.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(b.out_valid), 64'd0);
        chk("rst_out_data", 64'(b.out_data), 64'd0);
        chk("rst_out_tag", 64'(b.out_tag), 64'd0);
        chk("rst_in_ready", 64'(b.in_ready), 64'd1);
        chk("rst_n_out_valid", 64'(n.out_valid), 64'd0);
        chk("rst_n_in_ready", 64'(n.in_ready), 64'd1);
        reset_n = 1'b1;

        // Modes at default widths, one item at a time.
        for (int i = 0; i < 4; i++) begin
            b.in_valid = 1'b1; b.in_imm = vt[i].imm; b.in_op = vt[i].op; b.in_tag = vt[i].tag;
            b.out_ready = 1'b1;
            @(posedge clk); #1;
            b.in_valid = 1'b0;
            chk("mode_valid", 64'(b.out_valid), 64'd1);
            chk("mode_data", 64'(b.out_data), 64'(vt[i].exp));
            chk("mode_tag", 64'(b.out_tag), 64'(vt[i].tag));
            @(posedge clk); #1;
            chk("mode_drained", 64'(b.out_valid), 64'd0);
        end

        // Narrow widths.
        for (int i = 0; i < 4; i++) begin
            n.in_valid = 1'b1; n.in_imm = nt[i].imm; n.in_op = nt[i].op; n.in_tag = 3'(i);
            n.out_ready = 1'b1;
            @(posedge clk); #1;
            n.in_valid = 1'b0;
            chk("narrow_valid", 64'(n.out_valid), 64'd1);
            chk("narrow_data", 64'(n.out_data), 64'(nt[i].exp));
            @(posedge clk); #1;
        end

        // Backpressure: tags 1..6 with out_ready low for three cycles.
        idx = 1; gap = 0; saved = '0; drained_tags.delete();
        for (int c = 0; c < 30; c++) begin
            b.out_ready = (c >= 3);
            b.in_valid  = (idx <= 6);
            b.in_tag    = 5'(idx);
            b.in_imm    = 16'(idx * 32'h1111);
            b.in_op     = 2'(idx);
            #1;
            acc = b.in_valid && b.in_ready;
            if (c == 1) saved = b.out_data;
            if (c == 2) begin
                chk("bp_in_ready", 64'(b.in_ready), 64'd0);
                chk("bp_accepted", 64'(idx - 1), 64'(CAP));
                chk("bp_stable", 64'(b.out_data), 64'(saved));
            end
            if (c >= 3 && drained_tags.size() < 6 && !b.out_valid) gap++;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_gaps", 64'(gap), 64'd0);
        chk("bp_count", 64'(drained_tags.size()), 64'd6);
        for (int i = 0; i < 6 && i < drained_tags.size(); i++)
            chk("bp_order", 64'(drained_tags[i]), 64'(i + 1));

        // Flush with the buffer full and an item offered.
        b.out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) begin
            b.in_valid = 1'b1; b.in_tag = 5'(8 + k); b.in_imm = 16'h00F0; b.in_op = 2'd0;
            @(posedge clk); #1;
        end
        b.in_tag = 5'd7; flush = 1'b1;
        chk("fl_full_valid", 64'(b.out_valid), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; b.in_valid = 1'b0;
        chk("fl_valid_after", 64'(b.out_valid), 64'd0);
        // Flush while empty and ready: the offered item is dropped.
        b.in_valid = 1'b1; b.in_tag = 5'd7; flush = 1'b1;
        #1;
        chk("fl_empty_ready", 64'(b.in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; b.in_valid = 1'b0;
        chk("fl_drop_valid", 64'(b.out_valid), 64'd0);
        b.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("fl_no_ghost", 64'(b.out_valid), 64'd0);
        end

        // Async reset mid-cycle with the buffer full.
        b.out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) begin
            b.in_valid = 1'b1; b.in_tag = 5'(11 + k); b.in_imm = 16'h7FFF; b.in_op = 2'd1;
            @(posedge clk); #1;
        end
        b.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(b.out_valid), 64'd0);
        chk("arst_out_data", 64'(b.out_data), 64'd0);
        chk("arst_out_tag", 64'(b.out_tag), 64'd0);
        chk("arst_in_ready", 64'(b.in_ready), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        b.in_valid = 1'b1; b.in_imm = 16'h8001; b.in_op = 2'd1; b.in_tag = 5'd3; b.out_ready = 1'b1;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        chk("post_rst_valid", 64'(b.out_valid), 64'd1);
        chk("post_rst_data", 64'(b.out_data), 64'hFFFF8001);
        chk("post_rst_tag", 64'(b.out_tag), 64'd3);
        @(posedge clk); #1;

        // in_ready versus out_ready with one item held.
        b.out_ready = 1'b0;
        b.in_valid = 1'b1; b.in_imm = 16'h0001; b.in_op = 2'd0; b.in_tag = 5'd4;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        #1;
        chk("rdy_pass", 64'(b.in_ready), 64'd1);
        b.out_ready = 1'b0;
        #1;
`ifdef EXT_PIPE_SKID_EN
        chk("rdy_registered", 64'(b.in_ready), 64'd1);
`else
        chk("rdy_blocked", 64'(b.in_ready), 64'd0);
`endif
        b.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rdy_drained", 64'(b.out_valid), 64'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
